// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter
//   Round-robin arbiter sharing one datapath resource between N_REQ
//   requesters. A grant is held for the owner's whole transaction, with no
//   preemption. After each release there is one RELEASE cycle with gnt=0,
//   then arbitration resumes from IDLE. The rotating priority pointer moves
//   just past the previous owner.
//
//   Optional feature (compile-time macro ARB_WATCHDOG_EN):
//     A hold counter revokes a grant after HOLD_MAX GRANT cycles. The
//     revocation is flagged with a one-cycle timeout pulse and a sticky
//     timeout_id. Without the macro, grants are held indefinitely and
//     timeout/timeout_id are tied to zero.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   reset      : synchronous, active-high reset
//   req        : per-requester request level, held for the whole transaction
//   done       : per-requester end-of-transaction pulse (used from the owner only)
//   gnt        : registered one-hot grant
//   gnt_id     : encoded owner index; holds the last owner while idle
//   busy       : high in GRANT and RELEASE
//   timeout    : one-cycle pulse when the watchdog revokes a grant
//   timeout_id : index of the last revoked owner (sticky)
module rr_resource_arbiter #(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = 2,
    parameter int HOLD_MAX = 40,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             busy,
    output logic             timeout,
    output logic [IDX_W-1:0] timeout_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] ptr_next;
    logic             owner_release;

    // First requester at or after p, wrapping modulo N_REQ. The request
    // vector is rotated right by p, so bit 0 of the rotated copy is the
    // highest-priority requester. The lowest set bit of that copy gives the
    // offset from p.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [N_REQ-1:0] rot;
        int               off;
        int               w;
        rot = N_REQ'({r, r} >> p);
        off = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        w = int'(p) + off;
        if (w >= N_REQ) w = w - N_REQ;
        return IDX_W'(w);
    endfunction

    always_comb winner = rr_pick(req, ptr);

    // gnt is one-hot while granting, so masking with it selects the owner's
    // bits without an index. A dropped req and a done pulse arriving together
    // still form a single release.
    always_comb owner_release = ~(|(req & gnt)) | (|(done & gnt));

    // Explicit wrap so non-power-of-two N_REQ never lands on an unused index.
    always_comb ptr_next = (gnt_id == IDX_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef ARB_WATCHDOG_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_r;
    logic [IDX_W-1:0] timeout_id_r;
    logic             wd_expire;

    always_comb wd_expire = (hold_cnt == CNT_W'(HOLD_MAX - 1));

    assign timeout    = timeout_r;
    assign timeout_id = timeout_id_r;
`else
    assign timeout    = 1'b0;
    assign timeout_id = '0;

    // The watchdog sizing parameters have no effect in this build.
    logic unused_cfg;
    assign unused_cfg = ^(CNT_W'(HOLD_MAX));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            ptr    <= '0;
`ifdef ARB_WATCHDOG_EN
            hold_cnt     <= '0;
            timeout_r    <= 1'b0;
            timeout_id_r <= '0;
`endif
        end else begin
`ifdef ARB_WATCHDOG_EN
            timeout_r <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state  <= S_GRANT;
                        gnt    <= N_REQ'(1) << winner;
                        gnt_id <= winner;
                        busy   <= 1'b1;
`ifdef ARB_WATCHDOG_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (owner_release) begin
                        state <= S_RELEASE;
                        gnt   <= '0;
                        ptr   <= ptr_next;
                    end
`ifdef ARB_WATCHDOG_EN
                    // A normal release on the limit cycle wins: no pulse.
                    else if (wd_expire) begin
                        state        <= S_RELEASE;
                        gnt          <= '0;
                        ptr          <= ptr_next;
                        timeout_r    <= 1'b1;
                        timeout_id_r <= gnt_id;
                    end
                    if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
`endif
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
